seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_DIGITS, default 4: number of multiplexed digits; legal range 2..8.
- SLOT_CYC, default 50000: clock cycles each digit slot lasts; minimum 4.
- GUARD_CYC, default 2: blanking cycles at the start of each slot (anti-ghosting); legal range 1..SLOT_CYC-2.
- AN_ACT_LOW, default 1: 1 means digit enables are active-low.
REQ-002 Ports SHALL be:
- clk, in, 1: the single clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- load_valid, in, 1: a new display value is offered.
- load_data, in, 4*NUM_DIGITS: packed BCD nibbles; nibble 0 (LSBs) is the rightmost digit.
- load_ready, out, 1: the block can accept a load.
- lz_blank_en, in, 1: enables leading-zero suppression.
- bcd_out, out, 4: nibble driven to the seven-segment decoder.
- digit_en, out, NUM_DIGITS: one-hot digit enable, polarity per AN_ACT_LOW.
- frame_start, out, 1: one-cycle pulse at the start of a frame.

Function
REQ-003 Slot counter:
- Counts 0..SLOT_CYC-1, then wraps to 0.
- Digit index advances 0..NUM_DIGITS-1 on each wrap; after NUM_DIGITS-1 it returns to 0.
REQ-004 FSM has two states, GUARD and SHOW.
- GUARD is active while the slot count is below GUARD_CYC.
- SHOW covers the rest of the slot.
- GUARD->SHOW when slot count = GUARD_CYC-1.
- SHOW->GUARD on slot wrap.
REQ-005 In GUARD, all digit_en outputs SHALL be inactive.
REQ-006 In SHOW, the enable bit for the current index SHALL be active unless that digit is suppressed (REQ-010); all other bits are inactive.
REQ-007 bcd_out SHALL equal the current index's nibble of the display register in both states, registered, so the value is stable before the enable asserts.
REQ-008 Load handshake:
- A load is accepted when load_valid and load_ready are both 1 on the same edge.
- The accepted data goes into a shadow register, pending is set, and load_ready drops to 0 on the next cycle.
REQ-009 Shadow commit:
- At the digit-3->0 wrap (frame boundary), a pending shadow is copied into the display register.
- pending clears and load_ready returns to 1 on the same edge.
- The display register never changes mid-frame.
REQ-010 Leading-zero suppression (lz_blank_en=1):
- A digit is suppressed if it and every higher digit hold 0.
- Digit 0 is never suppressed.
- Suppression is evaluated on the display register, not the shadow.
REQ-011 Nibbles greater than 9 SHALL pass through unmodified on bcd_out; the decoder blanks them. They count as nonzero for suppression.
REQ-012 frame_start SHALL pulse for exactly one cycle on the first GUARD cycle of digit 0 in every frame, including the first frame after reset.
REQ-013 If load_valid is asserted on the same edge as a commit, the commit happens first and the new load is not accepted, because load_ready was 0 that cycle.
REQ-014 load_valid is ignored while load_ready=0; load_data may change freely without effect.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL set:
- slot count = 0, digit index = 0, state = GUARD.
- display register and shadow register = 0, pending = 0.
- bcd_out = 0.
- all digit_en inactive (all 1s when AN_ACT_LOW=1).
- load_ready = 1, frame_start = 0.
REQ-016 A reset mid-frame or mid-handshake SHALL discard any pending shadow. The first post-reset cycle SHALL be GUARD of digit 0, with frame_start=1.

Verification (NUM_DIGITS=4, SLOT_CYC=8, GUARD_CYC=2, AN_ACT_LOW=1)
REQ-017 The bench SHALL cover the following scenarios:
- Reset release, no load: frame_start pulses every 32 cycles. For each slot, digit_en=1111 for 2 cycles, then 1110/1101/1011/0111 in rotation for 6 cycles. bcd_out=0.
- load_data=16'h1234 accepted mid-frame: display is unchanged until the next frame_start. After it, bcd_out reads 4,3,2,1 across slots. load_ready is 0 from acceptance until the commit edge.
- Second load_valid while pending, data 16'h9999: ignored. The frame shows 16'h1234.
- lz_blank_en=1, data 16'h0050: digits 3 and 2 keep digit_en=1111 during SHOW. Digits 1 and 0 enable with bcd_out 5 and 0. Data 16'h0000 shows only digit 0.
- Data 16'h00A0 with lz_blank_en=1: digit 1 is enabled with bcd_out=A and is not suppressed.
- rst asserted during the SHOW of digit 2 with a load pending: the next cycle has digit_en=1111, bcd_out=0, load_ready=1, frame_start=1. The following frame displays 0000.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display-drive bundle for seg_scan_ctrl.
//   master : the producer side (offers display values, observes the drive pins)
//   slave  : the scan controller itself
// Signals:
//   load_valid  - a new packed-BCD display value is offered
//   load_data   - 4*NUM_DIGITS bits, nibble 0 (LSBs) is the rightmost digit
//   load_ready  - the controller can take a new value
//   lz_blank_en - enables leading-zero suppression
//   bcd_out     - nibble for the seven-segment decoder
//   digit_en    - one-hot digit enable (polarity set by the controller)
//   frame_start - one-cycle pulse on the first cycle of every frame
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;
    logic                    lz_blank_en;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_start;

    modport master (
        output load_valid, load_data, lz_blank_en,
        input  load_ready, bcd_out, digit_en, frame_start
    );

    modport slave (
        input  load_valid, load_data, lz_blank_en,
        output load_ready, bcd_out, digit_en, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Each digit owns a slot of SLOT_CYC cycles; the first GUARD_CYC cycles of a
// slot blank every digit enable to avoid ghosting, the rest show the digit.
// New values are taken into a shadow register and only copied to the display
// register at the frame boundary, so a frame is never torn.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - seg_scan_ctrl_if slave modport (load handshake, bcd_out, digit_en,
//         frame_start)
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SLOT_CYC   = 50000,
    parameter int GUARD_CYC  = 2,
    parameter bit AN_ACT_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    seg_scan_ctrl_if.slave bus
);
    localparam int SLOT_W = $clog2(SLOT_CYC);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;
    // XOR mask that turns an active-high one-hot vector into pin polarity
    localparam logic [NUM_DIGITS-1:0] EN_IDLE = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // A digit is blanked when it and every higher digit are zero; digit 0 always shows.
    function automatic logic lz_suppressed(input logic [DATA_W-1:0] disp, input logic [IDX_W-1:0] idx);
        logic zero_s;
        zero_s = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            zero_s = zero_s & ((d < int'(idx)) || (disp[4*d +: 4] == 4'h0));
        end
        return (idx != IDX_W'(0)) && zero_s;
    endfunction

    logic [SLOT_W-1:0]     slot_cnt_r, slot_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    state_t                state_r, state_nxt_s;
    logic [DATA_W-1:0]     display_r, display_nxt_s, shadow_r;
    logic                  pending_r, pending_nxt_s;
    logic                  load_ready_r;
    logic [3:0]            bcd_r, bcd_nxt_s;
    logic [NUM_DIGITS-1:0] digit_en_r, digit_en_nxt_s, en_act_s;
    logic                  frame_r, frame_nxt_s;
    logic                  slot_wrap_s, frame_wrap_s, accept_s, commit_s, supp_s;

    // Slot/digit counters, handshake and shadow-commit decisions
    always_comb begin
        slot_wrap_s   = (slot_cnt_r == SLOT_W'(SLOT_CYC - 1));
        frame_wrap_s  = slot_wrap_s && (idx_r == IDX_W'(NUM_DIGITS - 1));
        accept_s      = bus.load_valid && load_ready_r;
        commit_s      = frame_wrap_s && pending_r;
        slot_nxt_s    = slot_wrap_s ? SLOT_W'(0) : (slot_cnt_r + SLOT_W'(1));
        idx_nxt_s     = frame_wrap_s ? IDX_W'(0) : (slot_wrap_s ? (idx_r + IDX_W'(1)) : idx_r);
        display_nxt_s = commit_s ? shadow_r : display_r;
        // accept and commit are exclusive: a pending shadow holds load_ready low
        pending_nxt_s = accept_s ? 1'b1 : (commit_s ? 1'b0 : pending_r);
    end

    // GUARD/SHOW next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_GUARD: state_nxt_s = (slot_cnt_r == SLOT_W'(GUARD_CYC - 1)) ? ST_SHOW : ST_GUARD;
            ST_SHOW:  state_nxt_s = slot_wrap_s ? ST_GUARD : ST_SHOW;
            default:  state_nxt_s = ST_GUARD;
        endcase
    end

    // Output values for the upcoming cycle, so the registered pins line up with the state
    always_comb begin
        bcd_nxt_s = 4'h0;
        en_act_s  = {NUM_DIGITS{1'b0}};
        supp_s    = bus.lz_blank_en && lz_suppressed(display_nxt_s, idx_nxt_s);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            bcd_nxt_s   = (idx_nxt_s == IDX_W'(d)) ? display_nxt_s[4*d +: 4] : bcd_nxt_s;
            en_act_s[d] = (state_nxt_s == ST_SHOW) && (idx_nxt_s == IDX_W'(d)) && !supp_s;
        end
        digit_en_nxt_s = en_act_s ^ EN_IDLE;
        frame_nxt_s    = (slot_nxt_s == SLOT_W'(0)) && (idx_nxt_s == IDX_W'(0));
    end

    // State, data and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_r   <= SLOT_W'(0);
            idx_r        <= IDX_W'(0);
            state_r      <= ST_GUARD;
            display_r    <= {DATA_W{1'b0}};
            shadow_r     <= {DATA_W{1'b0}};
            pending_r    <= 1'b0;
            load_ready_r <= 1'b1;
            bcd_r        <= 4'h0;
            digit_en_r   <= EN_IDLE;
            // the cycle after reset is the first cycle of frame 0
            frame_r      <= 1'b1;
        end else begin
            slot_cnt_r   <= slot_nxt_s;
            idx_r        <= idx_nxt_s;
            state_r      <= state_nxt_s;
            display_r    <= display_nxt_s;
            shadow_r     <= accept_s ? bus.load_data : shadow_r;
            pending_r    <= pending_nxt_s;
            load_ready_r <= !pending_nxt_s;
            bcd_r        <= bcd_nxt_s;
            digit_en_r   <= digit_en_nxt_s;
            frame_r      <= frame_nxt_s;
        end
    end

    assign bus.load_ready  = load_ready_r;
    assign bus.bcd_out     = bcd_r;
    assign bus.digit_en    = digit_en_r;
    // held low while reset is asserted; fires on the first cycle after release
    assign bus.frame_start = frame_r && !rst;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, SLOT_CYC=8, GUARD_CYC=2,
// AN_ACT_LOW=1). Stimulus queues one expected frame per frame_start; the
// monitor pops a frame at every frame_start and checks every cycle of it.
module tb_seg_scan_ctrl;
    logic clk;
    logic rst;

    seg_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS(4),
        .SLOT_CYC  (8),
        .GUARD_CYC (2),
        .AN_ACT_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] disp;  // nibble per slot on bcd_out
        logic [15:0] en;    // digit_en during SHOW, 4 bits per slot
        int          len;   // cycles until the next frame_start
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    int     checks = 0;
    int     errors = 0;
    int     frames = 0;
    int     pos = 0;
    bit     active = 1'b0;
    int     slot;
    int     ph;
    logic [3:0] exp_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [15:0] d, input logic [15:0] e, input int len);
        frame_t f;
        f.disp = d;
        f.en   = e;
        f.len  = len;
        exp_q.push_back(f);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the cycle showing frame_start
    task automatic wait_fs();
        int k = 0;
        @(negedge clk);
        while (bus.frame_start !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL wait_fs timeout got %b exp 1", bus.frame_start);
        end
    endtask

    // Monitor: frame alignment and per-cycle digit_en / bcd_out
    always @(negedge clk) begin
        if (bus.frame_start === 1'b1) begin
            if (active) begin
                checks++;
                if (pos != cur.len) begin
                    errors++;
                    $display("FAIL frame_len got %0d exp %0d", pos, cur.len);
                end
            end
            if (exp_q.size() > 0) begin
                cur    = exp_q.pop_front();
                active = 1'b1;
                pos    = 0;
                frames++;
            end else begin
                active = 1'b0;
            end
        end else if (active && pos >= cur.len) begin
            checks++;
            errors++;
            $display("FAIL frame_start_missing got 0 exp 1 at pos %0d", pos);
            active = 1'b0;
        end
        if (active) begin
            slot   = pos / 8;
            ph     = pos % 8;
            exp_en = (ph < 2) ? 4'hF : cur.en[slot*4 +: 4];
            checks++;
            if (bus.digit_en !== exp_en) begin
                errors++;
                $display("FAIL digit_en frame %0d pos %0d got %b exp %b", frames - 1, pos, bus.digit_en, exp_en);
            end
            checks++;
            if (bus.bcd_out !== cur.disp[slot*4 +: 4]) begin
                errors++;
                $display("FAIL bcd_out frame %0d pos %0d got %h exp %h", frames - 1, pos, bus.bcd_out, cur.disp[slot*4 +: 4]);
            end
            pos++;
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst             = 1'b1;
        bus.load_valid  = 1'b0;
        bus.load_data   = 16'h0000;
        bus.lz_blank_en = 1'b0;
        push(16'h0000, 16'h7BDE, 32);   // F0 idle
        push(16'h0000, 16'h7BDE, 32);   // F1 load accepted mid-frame, not shown yet
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_digit_en", 16'(bus.digit_en), 16'h000F);
        chk("rst_bcd", 16'(bus.bcd_out), 16'h0000);
        chk("rst_ready", 16'(bus.load_ready), 16'h0001);
        chk("rst_frame_start", 16'(bus.frame_start), 16'h0000);
        @(posedge clk);
        #1 rst = 1'b0;

        wait_fs();                      // F0
        wait_fs();                      // F1
        step(10);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1234;
        push(16'h1234, 16'h7BDE, 32);   // F2
        step(1);
        bus.load_valid = 1'b0;
        bus.load_data  = 16'hFFFF;
        @(negedge clk);
        chk("ready_after_accept", 16'(bus.load_ready), 16'h0000);
        step(4);
        bus.load_valid = 1'b1;          // ignored: load pending
        bus.load_data  = 16'h9999;
        step(1);
        bus.load_valid = 1'b0;
        step(10);
        @(negedge clk);
        chk("ready_pending", 16'(bus.load_ready), 16'h0000);
        wait_fs();                      // F2
        chk("ready_after_commit", 16'(bus.load_ready), 16'h0001);
        push(16'h1234, 16'h7BDE, 32);   // F3 9999 never committed

        wait_fs();                      // F3
        bus.lz_blank_en = 1'b1;
        step(5);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h0050;
        push(16'h0050, 16'hFFDE, 32);   // F4
        step(1);
        bus.load_valid = 1'b0;

        wait_fs();                      // F4
        step(5);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h0000;
        push(16'h0000, 16'hFFFE, 32);   // F5 only digit 0 enabled
        step(1);
        bus.load_valid = 1'b0;

        wait_fs();                      // F5
        step(5);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h00A0;
        push(16'h00A0, 16'hFFDE, 32);   // F6 A counts as nonzero
        step(1);
        bus.load_valid = 1'b0;

        wait_fs();                      // F6
        push(16'h00A0, 16'h7BDE, 20);   // F7 cut by reset in digit 2 SHOW
        wait_fs();                      // F7
        bus.lz_blank_en = 1'b0;
        step(3);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h4321;
        push(16'h0000, 16'h7BDE, 32);   // F8 post-reset
        push(16'h0000, 16'h7BDE, 32);   // F9 pending shadow discarded
        step(1);
        bus.load_valid = 1'b0;
        @(negedge clk);
        chk("ready_before_rst", 16'(bus.load_ready), 16'h0000);
        step(15);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_digit_en", 16'(bus.digit_en), 16'h000F);
        chk("post_rst_bcd", 16'(bus.bcd_out), 16'h0000);
        chk("post_rst_ready", 16'(bus.load_ready), 16'h0001);
        chk("post_rst_frame_start", 16'(bus.frame_start), 16'h0001);

        wait_fs();                      // F9
        wait_fs();                      // F10, nothing queued
        @(negedge clk);
        chk("queue_empty", 16'(exp_q.size()), 16'h0000);
        chk("frames_seen", 16'(frames), 16'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
